// File: rtl/gate_checker.sv
`default_nettype none
// ============================================================================
// gate_checker
//   Compares NOT/NAND gate responses against expected values delayed by
//   LATENCY cycles and accumulates per-run error statistics.
//   Revision: 1.0
// ============================================================================
module gate_checker #(
  parameter int LATENCY    = 0,
  parameter int NUM_CHECKS = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_not,
  input  logic             in1_nand,
  input  logic             in2_nand,
  input  logic             out_not,
  input  logic             out_nand,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err_not,
  output logic             err_nand,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] check_count,
  output logic             first_err_valid,
  output logic [CNT_W-1:0] first_err_idx
);

  localparam logic [CNT_W-1:0] c_CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] c_NUM_CHECKS = CNT_W'(NUM_CHECKS);
  localparam logic [2:0]       c_FILL_LAST  = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [2:0]       r_fill_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_err_not;
  logic             r_err_nand;
  logic [CNT_W-1:0] r_err_count;
  logic [CNT_W-1:0] r_check_count;
  logic             r_first_err_valid;
  logic [CNT_W-1:0] r_first_err_idx;

  logic             w_exp_not;
  logic             w_exp_nand;
  logic             w_exp_not_d;
  logic             w_exp_nand_d;
  logic             w_mis_not;
  logic             w_mis_nand;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_exp_not  = ~in_not;
  assign w_exp_nand = ~(in1_nand & in2_nand);

  generate
    if (LATENCY == 0) begin : g_dly0
      assign w_exp_not_d  = w_exp_not;
      assign w_exp_nand_d = w_exp_nand;
    end else if (LATENCY == 1) begin : g_dly1
      logic r_not_pipe;
      logic r_nand_pipe;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_not_pipe  <= 1'b0;
          r_nand_pipe <= 1'b0;
        end else begin
          r_not_pipe  <= w_exp_not;
          r_nand_pipe <= w_exp_nand;
        end
      end
      assign w_exp_not_d  = r_not_pipe;
      assign w_exp_nand_d = r_nand_pipe;
    end else begin : g_dlyn
      logic [LATENCY-1:0] r_not_pipe;
      logic [LATENCY-1:0] r_nand_pipe;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_not_pipe  <= '0;
          r_nand_pipe <= '0;
        end else begin
          r_not_pipe  <= {r_not_pipe[LATENCY-2:0], w_exp_not};
          r_nand_pipe <= {r_nand_pipe[LATENCY-2:0], w_exp_nand};
        end
      end
      assign w_exp_not_d  = r_not_pipe[LATENCY-1];
      assign w_exp_nand_d = r_nand_pipe[LATENCY-1];
    end
  endgenerate

  // Case inequality so an X/Z response is reported as a mismatch.
  assign w_mis_not  = (out_not !== w_exp_not_d);
  assign w_mis_nand = (out_nand !== w_exp_nand_d);
  assign w_cnt_inc  = r_check_count + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state           <= S_IDLE;
      r_fill_cnt        <= 3'd0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_err_not         <= 1'b0;
      r_err_nand        <= 1'b0;
      r_err_count       <= '0;
      r_check_count     <= '0;
      r_first_err_valid <= 1'b0;
      r_first_err_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state           <= (LATENCY > 0) ? S_FILL : S_CHECK;
            r_fill_cnt        <= 3'd0;
            r_busy            <= 1'b1;
            r_done            <= 1'b0;
            r_err_not         <= 1'b0;
            r_err_nand        <= 1'b0;
            r_err_count       <= '0;
            r_check_count     <= '0;
            r_first_err_valid <= 1'b0;
            r_first_err_idx   <= '0;
          end
        end

        S_FILL: begin
          if (r_fill_cnt == c_FILL_LAST) begin
            r_state <= S_CHECK;
          end else begin
            r_fill_cnt <= r_fill_cnt + 3'd1;
          end
        end

        S_CHECK: begin
          if (w_mis_not || w_mis_nand) begin
            if (r_err_count != c_CNT_MAX) begin
              r_err_count <= r_err_count + 1'b1;
            end
            if (w_mis_not) begin
              r_err_not <= 1'b1;
            end
            if (w_mis_nand) begin
              r_err_nand <= 1'b1;
            end
            if (!r_first_err_valid) begin
              r_first_err_valid <= 1'b1;
              r_first_err_idx   <= r_check_count;
            end
          end
          r_check_count <= w_cnt_inc;
          if (w_cnt_inc == c_NUM_CHECKS) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_done & (r_err_count == '0);
  assign err_not         = r_err_not;
  assign err_nand        = r_err_nand;
  assign err_count       = r_err_count;
  assign check_count     = r_check_count;
  assign first_err_valid = r_first_err_valid;
  assign first_err_idx   = r_first_err_idx;

endmodule
`default_nettype wire

// File: tb/tb_gate_checker.sv
`default_nettype none
// ============================================================================
// tb_gate_checker
//   Directed bench: gate_checker at LATENCY 0 and 2 against driven and
//   modelled gate responses.
//   Revision: 1.0
// ============================================================================
module tb_gate_checker;

  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst;

  int total = 0;
  int bad   = 0;

  // Instance A: LATENCY=0, responses driven directly by the bench.
  logic start_a, in_not_a, in1_a, in2_a, out_not_a, out_nand_a;
  logic busy_a, done_a, pass_a, err_not_a, err_nand_a, fev_a;
  logic [CW-1:0] ecnt_a, ccnt_a, fidx_a;

  // Instances B (LATENCY=2) and C (LATENCY=0) share a 2-stage gate model.
  logic start_m, min_not, min1, min2;
  logic m1_not, m2_not, m1_nand, m2_nand;
  logic busy_b, done_b, pass_b, err_not_b, err_nand_b, fev_b;
  logic [CW-1:0] ecnt_b, ccnt_b, fidx_b;
  logic busy_c, done_c, pass_c, err_not_c, err_nand_c, fev_c;
  logic [CW-1:0] ecnt_c, ccnt_c, fidx_c;

  // Run stimulus: in_not 0,1,0,1; (in1,in2) = (0,1),(1,0),(0,1),(1,0).
  logic [3:0] va_not = 4'b1010;
  logic [3:0] va_in1 = 4'b1010;
  logic [3:0] va_in2 = 4'b0101;

  gate_checker #(.LATENCY(0), .NUM_CHECKS(4), .CNT_W(CW)) dut_a (
    .clk(clk), .reset(rst), .start(start_a),
    .in_not(in_not_a), .in1_nand(in1_a), .in2_nand(in2_a),
    .out_not(out_not_a), .out_nand(out_nand_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_not(err_not_a), .err_nand(err_nand_a),
    .err_count(ecnt_a), .check_count(ccnt_a),
    .first_err_valid(fev_a), .first_err_idx(fidx_a)
  );

  gate_checker #(.LATENCY(2), .NUM_CHECKS(4), .CNT_W(CW)) dut_b (
    .clk(clk), .reset(rst), .start(start_m),
    .in_not(min_not), .in1_nand(min1), .in2_nand(min2),
    .out_not(m2_not), .out_nand(m2_nand),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_not(err_not_b), .err_nand(err_nand_b),
    .err_count(ecnt_b), .check_count(ccnt_b),
    .first_err_valid(fev_b), .first_err_idx(fidx_b)
  );

  gate_checker #(.LATENCY(0), .NUM_CHECKS(4), .CNT_W(CW)) dut_c (
    .clk(clk), .reset(rst), .start(start_m),
    .in_not(min_not), .in1_nand(min1), .in2_nand(min2),
    .out_not(m2_not), .out_nand(m2_nand),
    .busy(busy_c), .done(done_c), .pass(pass_c),
    .err_not(err_not_c), .err_nand(err_nand_c),
    .err_count(ecnt_c), .check_count(ccnt_c),
    .first_err_valid(fev_c), .first_err_idx(fidx_c)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m1_not <= 1'b0; m2_not <= 1'b0; m1_nand <= 1'b0; m2_nand <= 1'b0;
    end else begin
      m1_not  <= ~min_not;
      m2_not  <= m1_not;
      m1_nand <= ~(min1 & min2);
      m2_nand <= m1_nand;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic pulse_start_a();
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Drives n compare vectors; optional faults on the responses.
  task automatic feed_a(input int n, input int stuck, input int glitch_k,
                        input int x_k, input int start_k);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      start_a    = (k == start_k);
      in_not_a   = va_not[k];
      in1_a      = va_in1[k];
      in2_a      = va_in2[k];
      out_not_a  = ~va_not[k] ^ (k == glitch_k);
      out_nand_a = (stuck != 0) ? 1'b0 : ~(va_in1[k] & va_in2[k]);
      if (k == x_k) out_nand_a = 1'bx;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_a = 0; in_not_a = 0; in1_a = 0; in2_a = 0; out_not_a = 1; out_nand_a = 1;
    start_m = 0; min_not = 0; min1 = 0; min2 = 0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy_a, done_a, pass_a, err_not_a, err_nand_a, fev_a, ecnt_a, ccnt_a, fidx_a} !== 30'd0) begin
      bad++;
      $display("FAIL reset_a: got busy=%b done=%b pass=%b ecnt=%0d ccnt=%0d, expected all 0",
               busy_a, done_a, pass_a, ecnt_a, ccnt_a);
    end
    total++;
    if ({busy_b, done_b, ecnt_b, ccnt_b, busy_c, done_c, ecnt_c, ccnt_c} !== 36'd0) begin
      bad++;
      $display("FAIL reset_bc: got busy_b=%b done_b=%b busy_c=%b done_c=%b, expected all 0",
               busy_b, done_b, busy_c, done_c);
    end
    rst = 1'b0;
  endtask

  task automatic test_clean();
    pulse_start_a();
    total++;
    if ({busy_a, done_a, ccnt_a} !== {1'b1, 1'b0, 8'd0}) begin
      bad++;
      $display("FAIL clean_start: got busy=%b done=%b ccnt=%0d, expected 1 0 0", busy_a, done_a, ccnt_a);
    end
    feed_a(4, 0, -1, -1, -1);
    total++;
    if ({busy_a, done_a, pass_a, fev_a, ecnt_a, ccnt_a} !== {1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd4}) begin
      bad++;
      $display("FAIL clean_run: got busy=%b done=%b pass=%b fev=%b ecnt=%0d ccnt=%0d, expected 0 1 1 0 0 4",
               busy_a, done_a, pass_a, fev_a, ecnt_a, ccnt_a);
    end
  endtask

  task automatic test_stuck_nand();
    pulse_start_a();
    feed_a(4, 1, -1, -1, -1);
    total++;
    if ({done_a, pass_a, err_not_a, err_nand_a, fev_a, ecnt_a, fidx_a} !==
        {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd4, 8'd0}) begin
      bad++;
      $display("FAIL stuck_nand: got done=%b pass=%b en=%b ed=%b fev=%b ecnt=%0d fidx=%0d, expected 1 0 0 1 1 4 0",
               done_a, pass_a, err_not_a, err_nand_a, fev_a, ecnt_a, fidx_a);
    end
  endtask

  task automatic test_glitch();
    pulse_start_a();
    feed_a(4, 0, 2, -1, -1);
    total++;
    if ({done_a, pass_a, err_not_a, err_nand_a, fev_a, ecnt_a, fidx_a} !==
        {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 8'd2}) begin
      bad++;
      $display("FAIL glitch: got done=%b pass=%b en=%b ed=%b fev=%b ecnt=%0d fidx=%0d, expected 1 0 1 0 1 1 2",
               done_a, pass_a, err_not_a, err_nand_a, fev_a, ecnt_a, fidx_a);
    end
  endtask

  task automatic test_x_response();
    pulse_start_a();
    feed_a(4, 0, -1, 1, -1);
    total++;
    if ({done_a, pass_a, err_not_a, err_nand_a, ecnt_a, fidx_a} !==
        {1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 8'd1}) begin
      bad++;
      $display("FAIL x_resp: got done=%b pass=%b en=%b ed=%b ecnt=%0d fidx=%0d, expected 1 0 0 1 1 1",
               done_a, pass_a, err_not_a, err_nand_a, ecnt_a, fidx_a);
    end
  endtask

  task automatic test_start_in_check();
    pulse_start_a();
    feed_a(4, 0, -1, -1, 1);
    total++;
    if ({done_a, pass_a, ccnt_a, ecnt_a} !== {1'b1, 1'b1, 8'd4, 8'd0}) begin
      bad++;
      $display("FAIL start_in_check: got done=%b pass=%b ccnt=%0d ecnt=%0d, expected 1 1 4 0",
               done_a, pass_a, ccnt_a, ecnt_a);
    end
  endtask

  task automatic test_restart_from_done();
    pulse_start_a();
    feed_a(4, 1, -1, -1, -1);
    pulse_start_a();
    total++;
    if ({busy_a, done_a, err_nand_a, fev_a, ecnt_a, ccnt_a} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0}) begin
      bad++;
      $display("FAIL restart_clear: got busy=%b done=%b ed=%b fev=%b ecnt=%0d ccnt=%0d, expected 1 0 0 0 0 0",
               busy_a, done_a, err_nand_a, fev_a, ecnt_a, ccnt_a);
    end
    feed_a(4, 0, -1, -1, -1);
    total++;
    if ({done_a, pass_a, ccnt_a} !== {1'b1, 1'b1, 8'd4}) begin
      bad++;
      $display("FAIL restart_run: got done=%b pass=%b ccnt=%0d, expected 1 1 4", done_a, pass_a, ccnt_a);
    end
  endtask

  task automatic test_reset_mid_check();
    pulse_start_a();
    feed_a(2, 0, 0, -1, -1);
    total++;
    if ({busy_a, ecnt_a, ccnt_a} !== {1'b1, 8'd1, 8'd2}) begin
      bad++;
      $display("FAIL mid_pre: got busy=%b ecnt=%0d ccnt=%0d, expected 1 1 2", busy_a, ecnt_a, ccnt_a);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({busy_a, done_a, pass_a, err_not_a, err_nand_a, fev_a, ecnt_a, ccnt_a, fidx_a} !== 30'd0) begin
      bad++;
      $display("FAIL mid_reset: got busy=%b done=%b en=%b ecnt=%0d ccnt=%0d, expected all 0",
               busy_a, done_a, err_not_a, ecnt_a, ccnt_a);
    end
    @(negedge clk);
    rst = 1'b0;
    pulse_start_a();
    feed_a(4, 0, -1, -1, -1);
    total++;
    if ({done_a, pass_a, ecnt_a, ccnt_a} !== {1'b1, 1'b1, 8'd0, 8'd4}) begin
      bad++;
      $display("FAIL mid_rerun: got done=%b pass=%b ecnt=%0d ccnt=%0d, expected 1 1 0 4",
               done_a, pass_a, ecnt_a, ccnt_a);
    end
  endtask

  // Period-4 stimulus so a 2-cycle slip always inverts the response.
  task automatic test_latency();
    logic [3:0] pn;
    logic [3:0] p1;
    int nbusy;
    pn = 4'b1100;
    p1 = 4'b0011;
    nbusy = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      start_m = (i == 2);
      min_not = pn[i % 4];
      min1    = p1[i % 4];
      min2    = 1'b1;
      @(posedge clk);
      #1;
      if (i >= 2 && i <= 9 && busy_b) nbusy++;
    end
    total++;
    if (nbusy !== 6) begin
      bad++;
      $display("FAIL lat2_busy: got %0d busy cycles, expected 6", nbusy);
    end
    total++;
    if ({done_b, pass_b, ecnt_b, ccnt_b} !== {1'b1, 1'b1, 8'd0, 8'd4}) begin
      bad++;
      $display("FAIL lat2_pass: got done=%b pass=%b ecnt=%0d ccnt=%0d, expected 1 1 0 4",
               done_b, pass_b, ecnt_b, ccnt_b);
    end
    total++;
    if ({done_c, pass_c, err_not_c, err_nand_c, ecnt_c, fidx_c} !==
        {1'b1, 1'b0, 1'b1, 1'b1, 8'd4, 8'd0}) begin
      bad++;
      $display("FAIL lat0_model: got done=%b pass=%b en=%b ed=%b ecnt=%0d fidx=%0d, expected 1 0 1 1 4 0",
               done_c, pass_c, err_not_c, err_nand_c, ecnt_c, fidx_c);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_stuck_nand();
    test_glitch();
    test_x_response();
    test_start_in_check();
    test_restart_from_done();
    test_reset_mid_check();
    test_latency();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
